// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux4
//  Brief    : Four-lane time-division demultiplexer. Tracks the slot index of
//             a slot-serialised stream, steers each valid beat into its lane,
//             and publishes a complete 4-lane frame over a valid/ready
//             handshake. A frame completing while the previous one is still
//             unconsumed is dropped and flagged on the sticky overflow output.
//  Options  : `define TDM_DEMUX4_SYNC_CHK_EN to resynchronise on a misaligned
//             frame_sync in COLLECT and pulse sync_err; otherwise sync_err is
//             tied low and frame_sync is only honoured while hunting.
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [1:0]           sel,
    output logic [4*WIDTH-1:0]   dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic                 sync_err
);

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                sel_q, sel_d;
    // Lanes 0..2 of the frame under assembly; lane 3 is taken straight from
    // the completing beat, so it never needs a shadow register.
    logic [2:0][WIDTH-1:0]     shadow_q, shadow_d;
    logic [4*WIDTH-1:0]        dout_q, dout_d;
    logic                      out_valid_q, out_valid_d;
    logic                      overflow_q, overflow_d;
`ifdef TDM_DEMUX4_SYNC_CHK_EN
    logic                      sync_err_q, sync_err_d;
`endif

    // A new frame may load when the output slot is empty or being emptied now.
    logic                      can_load;
    assign can_load = !out_valid_q || out_ready;

    // Next-state computation: slot tracking, lane steering and frame publish.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        shadow_d    = shadow_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
`ifdef TDM_DEMUX4_SYNC_CHK_EN
        sync_err_d  = 1'b0;
`endif

        // Handshake completes; a frame loading this same edge re-raises it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (din_valid) begin
            if (state_q == ST_HUNT) begin
                // Only a frame_sync-qualified beat establishes alignment.
                if (frame_sync) begin
                    shadow_d[0] = din;
                    sel_d       = 2'd1;
                    state_d     = ST_COLLECT;
                end
            end else begin
`ifdef TDM_DEMUX4_SYNC_CHK_EN
                if (frame_sync && (sel_q != 2'd0)) begin
                    // Misaligned sync: abandon the partial frame and restart
                    // with this beat as slot 0.
                    sync_err_d  = 1'b1;
                    shadow_d[0] = din;
                    sel_d       = 2'd1;
                end else
`endif
                begin
                    case (sel_q)
                        2'd0:    shadow_d[0] = din;
                        2'd1:    shadow_d[1] = din;
                        2'd2:    shadow_d[2] = din;
                        default: begin
                            if (can_load) begin
                                dout_d      = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                                out_valid_d = 1'b1;
                            end else begin
                                overflow_d  = 1'b1;
                            end
                        end
                    endcase
                    // Free-running wrap 3 -> 0 keeps alignment without sync.
                    sel_d = sel_q + 2'd1;
                end
            end
        end
    end

    // State and output registers; reset takes effect without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            sel_q       <= 2'd0;
            shadow_q    <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef TDM_DEMUX4_SYNC_CHK_EN
            sync_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            shadow_q    <= shadow_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
`ifdef TDM_DEMUX4_SYNC_CHK_EN
            sync_err_q  <= sync_err_d;
`endif
        end
    end

    assign sel       = sel_q;
    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
`ifdef TDM_DEMUX4_SYNC_CHK_EN
    assign sync_err  = sync_err_q;
`else
    assign sync_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux4
//  Brief    : Directed self-checking bench for tdm_demux4 with WIDTH=1.
//             Expectations follow TDM_DEMUX4_SYNC_CHK_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

    localparam int C_WIDTH = 1;

    logic               clk;
    logic               rst;
    logic [C_WIDTH-1:0] din;
    logic               din_valid;
    logic               frame_sync;
    logic [1:0]         sel;
    logic [4*C_WIDTH-1:0] dout;
    logic               out_valid;
    logic               out_ready;
    logic               overflow;
    logic               sync_err;

    int n_checks = 0;
    int n_errors = 0;

    tdm_demux4 #(.WIDTH(C_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .sel        (sel),
        .dout       (dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one cycle of input, then sample just after the capturing edge.
    task automatic drive(input logic v, input logic d, input logic fs);
        @(negedge clk);
        din_valid  = v;
        din        = d;
        frame_sync = fs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        out_ready  = 1'b1;
        #12;
        check("rst_sel",       32'(sel),       32'd0);
        check("rst_dout",      32'(dout),      32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_sync_err",  32'(sync_err),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single frame 1010, out_ready high.
        drive(1'b1, 1'b0, 1'b1); check("f1_sel1", 32'(sel), 32'd1); check("f1_nv1", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b1, 1'b0); check("f1_sel2", 32'(sel), 32'd2);
        drive(1'b1, 1'b0, 1'b0); check("f1_sel3", 32'(sel), 32'd3); check("f1_nv3", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b1, 1'b0); check("f1_sel0", 32'(sel), 32'd0);
        check("f1_valid", 32'(out_valid), 32'd1);
        check("f1_dout",  32'(dout),      32'b1010);
        drive(1'b0, 1'b0, 1'b0); check("f1_pulse_end", 32'(out_valid), 32'd0);
        check("f1_sel_hold", 32'(sel), 32'd0);

        // Back-to-back frames 1010 then 0001 without frame_sync on the second.
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("b2b_valid_a", 32'(out_valid), 32'd1);
        check("b2b_dout_a",  32'(dout),      32'b1010);
        drive(1'b1, 1'b1, 1'b0); check("b2b_gap", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("b2b_valid_b", 32'(out_valid), 32'd1);
        check("b2b_dout_b",  32'(dout),      32'b0001);
        check("b2b_ovf",     32'(overflow),  32'd0);
        drive(1'b0, 1'b0, 1'b0); check("b2b_pulse_end", 32'(out_valid), 32'd0);

        // Backpressure: first frame 0011 held, second 0110 dropped.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_dout",  32'(dout),      32'b0011);
        drive(1'b0, 1'b0, 1'b0);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_dout",  32'(dout),      32'b0011);
        check("bp_no_ovf",     32'(overflow),  32'd0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("bp_ovf",        32'(overflow),  32'd1);
        check("bp_keep_dout",  32'(dout),      32'b0011);
        check("bp_keep_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        check("bp_ovf_sticky", 32'(overflow),  32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("bp_rst_ovf",   32'(overflow),  32'd0);
        check("bp_rst_valid", 32'(out_valid), 32'd0);
        check("bp_rst_dout",  32'(dout),      32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;

        // Hunt: three unsynchronised beats discarded, then aligned frame 1000.
        drive(1'b1, 1'b1, 1'b0); check("hunt_sel_a", 32'(sel), 32'd0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0); check("hunt_sel_c", 32'(sel), 32'd0);
        check("hunt_nv", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b1, 1'b1); check("hunt_fs_invalid", 32'(sel), 32'd0);
        drive(1'b1, 1'b0, 1'b1); check("hunt_sel1", 32'(sel), 32'd1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("hunt_valid", 32'(out_valid), 32'd1);
        check("hunt_dout",  32'(dout),      32'b1000);

        // Misaligned frame_sync on the third beat of a frame.
        drive(1'b1, 1'b1, 1'b1); check("sc_sel1", 32'(sel), 32'd1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX4_SYNC_CHK_EN
        check("sc_err",   32'(sync_err),  32'd1);
        check("sc_sel",   32'(sel),       32'd1);
        check("sc_nv",    32'(out_valid), 32'd0);
        drive(1'b1, 1'b1, 1'b0); check("sc_err_end", 32'(sync_err), 32'd0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("sc_valid", 32'(out_valid), 32'd1);
        check("sc_dout",  32'(dout),      32'b0110);
        check("sc_sel0",  32'(sel),       32'd0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
`else
        check("sc_err",   32'(sync_err),  32'd0);
        check("sc_sel",   32'(sel),       32'd3);
        drive(1'b1, 1'b1, 1'b0);
        check("sc_valid", 32'(out_valid), 32'd1);
        check("sc_dout",  32'(dout),      32'b1011);
        check("sc_sel0",  32'(sel),       32'd0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
`endif
        check("ar_sel2", 32'(sel), 32'd2);

        // Asynchronous reset between edges with sel=2, then realign.
        @(negedge clk);
        din_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_sel_now",   32'(sel),       32'd0);
        check("ar_valid_now", 32'(out_valid), 32'd0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0); check("ar_hunt", 32'(sel), 32'd0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("ar_valid", 32'(out_valid), 32'd1);
        check("ar_dout",  32'(dout),      32'b0101);
        check("ar_ovf",   32'(overflow),  32'd0);
        drive(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
